systolic_array_scheduler: RTL and testbench

Sequencing controller for an N×N grid of bfloat16 systolic processing elements. It accepts a job command of K operand beats, clears the PE accumulators, and meters operand beats from an external feeder via a request/valid handshake. Each beat is broadcast as a diagonal wavefront of per-PE start pulses. The block then drains the array and reports completion with a done handshake. It sits between the host/DMA command logic and the PE grid's start/clear controls.

---
 rtl/systolic_array_scheduler.sv | 157 +++++++++++++++
 tb/tb_systolic_array_scheduler.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_array_scheduler.sv
// Job sequencer for an NxN bfloat16 systolic grid: clears the PEs, meters operand beats,
// fans each beat out as a diagonal start wavefront, then drains and hands back a done token.
module systolic_array_scheduler #(
  parameter int N        = 4,
  parameter int KW       = 8,
  parameter int PE_LAT   = 3,
  parameter int BEAT_GAP = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           cmd_valid,
  input  logic [KW-1:0]  cmd_k,
  output logic           cmd_ready,
  input  logic           abort,
  output logic           op_req,
  input  logic           op_valid,
  output logic [KW-1:0]  beat_idx,
  output logic [N*N-1:0] pe_start,
  output logic           pe_clear,
  output logic           busy,
  output logic           done_valid,
  input  logic           done_ready
);

  localparam int WW        = 2*N - 1;
  localparam int DRAIN_CYC = 2*N - 2 + PE_LAT;
  localparam int DW        = (DRAIN_CYC > 0) ? $clog2(DRAIN_CYC + 1) : 1;
  localparam int GW        = (BEAT_GAP > 1) ? $clog2(BEAT_GAP) : 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [KW-1:0]   beats_left_r;
  logic [KW-1:0]   beat_idx_r;
  logic [GW-1:0]   gap_r;
  logic [DW-1:0]   drain_r;
  logic [WW-1:0]   wave_r;
  logic [WW-1:0]   wave_nxt_s;
  logic            abort_clr_r;
  logic            fire_s;
  logic            last_fire_s;

  assign fire_s      = op_req && op_valid;
  assign last_fire_s = fire_s && (beats_left_r == KW'(1));
  assign beat_idx    = beat_idx_r;

  // PE(i,j) sees the beat i+j cycles after PE(0,0)
  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      assign pe_start[i*N+j] = wave_r[i+j];
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; abort overrides every state
  always_comb begin
    state_nxt_s = state_r;
    if (abort) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:  if (cmd_valid) state_nxt_s = ST_CLEAR; else state_nxt_s = ST_IDLE;
        ST_CLEAR: if (beats_left_r != KW'(0)) state_nxt_s = ST_FEED; else state_nxt_s = ST_DONE;
        ST_FEED:  if (last_fire_s) state_nxt_s = ST_DRAIN; else state_nxt_s = ST_FEED;
        ST_DRAIN: if (drain_r == DW'(0)) state_nxt_s = ST_DONE; else state_nxt_s = ST_DRAIN;
        ST_DONE:  if (done_ready) state_nxt_s = ST_IDLE; else state_nxt_s = ST_DONE;
        default:  state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Output decode
  always_comb begin
    cmd_ready  = 1'b0;
    op_req     = 1'b0;
    busy       = 1'b1;
    done_valid = 1'b0;
    pe_clear   = (state_r == ST_CLEAR) || abort_clr_r;
    case (state_r)
      ST_IDLE: begin
        cmd_ready = !abort;
        busy      = 1'b0;
      end
      ST_FEED:  op_req = (gap_r == GW'(0)) && (beats_left_r != KW'(0)) && !abort;
      ST_DONE:  done_valid = 1'b1;
      default:  busy = 1'b1;
    endcase
  end

  // Wavefront shift-in of the fire strobe
  always_comb begin
    wave_nxt_s    = wave_r << 1;
    wave_nxt_s[0] = fire_s;
  end

  // Beat counters, gap metering, drain timer and wavefront
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beats_left_r <= KW'(0);
      beat_idx_r   <= KW'(0);
      gap_r        <= GW'(0);
      drain_r      <= DW'(0);
      wave_r       <= WW'(0);
      abort_clr_r  <= 1'b0;
    end else if (abort) begin
      beats_left_r <= KW'(0);
      beat_idx_r   <= KW'(0);
      gap_r        <= GW'(0);
      drain_r      <= DW'(0);
      wave_r       <= WW'(0);
      abort_clr_r  <= 1'b1;
    end else begin
      abort_clr_r <= 1'b0;
      wave_r      <= wave_nxt_s;
      if (state_r == ST_IDLE && cmd_valid) begin
        beats_left_r <= cmd_k;
        beat_idx_r   <= KW'(0);
      end else if (fire_s) begin
        beats_left_r <= beats_left_r - KW'(1);
        beat_idx_r   <= beat_idx_r + KW'(1);
      end else begin
        beats_left_r <= beats_left_r;
        beat_idx_r   <= beat_idx_r;
      end
      if (fire_s) begin
        gap_r <= GW'(BEAT_GAP - 1);
      end else if (gap_r != GW'(0)) begin
        gap_r <= gap_r - GW'(1);
      end else begin
        gap_r <= gap_r;
      end
      if (last_fire_s) begin
        drain_r <= DW'(DRAIN_CYC);
      end else if (state_r == ST_DRAIN && drain_r != DW'(0)) begin
        drain_r <= drain_r - DW'(1);
      end else begin
        drain_r <= drain_r;
      end
    end
  end

endmodule

// File: tb/tb_systolic_array_scheduler.sv
// Bench for systolic_array_scheduler: directed table, randomized jobs against an event-time
// reference model, a BEAT_GAP=3 instance, abort and asynchronous reset sequences.
module tb_systolic_array_scheduler;

  localparam int N    = 4;
  localparam int KW   = 8;
  localparam int PL   = 3;
  localparam int DR   = 2*N - 2 + PL;
  localparam int MAXT = 128;

  logic           clk = 1'b0;
  logic           reset;
  logic           cmd_valid, abort, op_valid, done_ready;
  logic [KW-1:0]  cmd_k;
  logic           cmd_ready, op_req, pe_clear, busy, done_valid;
  logic [KW-1:0]  beat_idx;
  logic [N*N-1:0] pe_start;

  logic           g_cmd_valid, g_abort, g_op_valid, g_done_ready;
  logic [KW-1:0]  g_cmd_k;
  logic           g_cmd_ready, g_op_req, g_pe_clear, g_busy, g_done_valid;
  logic [KW-1:0]  g_beat_idx;
  logic [N*N-1:0] g_pe_start;

  always #5 clk = ~clk;

  systolic_array_scheduler #(.N(N), .KW(KW), .PE_LAT(PL), .BEAT_GAP(1)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_k(cmd_k), .cmd_ready(cmd_ready),
    .abort(abort), .op_req(op_req), .op_valid(op_valid), .beat_idx(beat_idx),
    .pe_start(pe_start), .pe_clear(pe_clear), .busy(busy), .done_valid(done_valid),
    .done_ready(done_ready));

  systolic_array_scheduler #(.N(N), .KW(KW), .PE_LAT(PL), .BEAT_GAP(3)) dut_gap (
    .clk(clk), .reset(reset), .cmd_valid(g_cmd_valid), .cmd_k(g_cmd_k), .cmd_ready(g_cmd_ready),
    .abort(g_abort), .op_req(g_op_req), .op_valid(g_op_valid), .beat_idx(g_beat_idx),
    .pe_start(g_pe_start), .pe_clear(g_pe_clear), .busy(g_busy), .done_valid(g_done_valid),
    .done_ready(g_done_ready));

  int   checks   = 0;
  int   failures = 0;
  int   prev_bi  = 0;
  logic ov_a [0:MAXT-1];
  logic dr_a [0:MAXT-1];

  typedef struct {
    int k; int stall_s; int stall_len; int dr_at;
    int exp_done; int exp_pe15; int exp_idle;
  } vec_t;

  typedef struct { logic oq; int bi; logic pe0; } gvec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pack(input logic cr, input logic bz, input logic pc,
                                       input logic dv, input logic oq,
                                       input logic [KW-1:0] bi, input logic [N*N-1:0] pe);
    return {3'b000, cr, bz, pc, dv, oq, bi, pe};
  endfunction

  function automatic logic [31:0] dut_vec();
    return pack(cmd_ready, busy, pe_clear, done_valid, op_req, beat_idx, pe_start);
  endfunction

  // One job accepted at t=0; expectations derive from fire times, not from DUT state.
  task automatic run_job(input int k, output int done_first, output int pe15_last,
                         output int idle_at);
    int fires[$];
    int dstart, r, nf, lastf, d;
    logic [N*N-1:0] epe;
    logic eoq;
    done_first = -1; pe15_last = -1; idle_at = -1;
    for (int t = 2; t < MAXT && fires.size() < k; t++)
      if (ov_a[t]) fires.push_back(t);
    if (fires.size() < k) begin
      check("model_fire_budget", 32'(fires.size()), 32'(k));
      return;
    end
    dstart = (k == 0) ? 2 : fires[k-1] + 2 + DR;
    r = dstart;
    while (r < MAXT-2 && !dr_a[r]) r++;
    for (int t = 0; t <= r + 1; t++) begin
      cmd_valid = (t == 0); cmd_k = KW'(k); abort = 1'b0;
      op_valid = ov_a[t]; done_ready = dr_a[t];
      nf = 0; lastf = -100;
      epe = '0;
      foreach (fires[f]) begin
        if (fires[f] < t) begin nf++; lastf = fires[f]; end
        d = t - fires[f] - 1;
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++)
            if (i + j == d) epe[i*N+j] = 1'b1;
      end
      eoq = (k > 0) && (t >= 2) && (nf < k) && (t >= lastf + 1);
      @(negedge clk);
      check($sformatf("job k=%0d t=%0d", k, t), dut_vec(),
            pack(t == 0 || t == r + 1, t >= 1 && t <= r, t == 1, t >= dstart && t <= r, eoq,
                 (t == 0) ? KW'(prev_bi) : KW'(nf), epe));
      if (done_valid && done_first < 0) done_first = t;
      if (pe_start[N*N-1]) pe15_last = t;
      if (t >= 1 && !busy && idle_at < 0) idle_at = t;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    prev_bi = k;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  vecs [5];
    gvec_t gv [8];
    int df, pl, ia, k, p, pd;
    logic acc_pe, acc_dv, acc_pc;

    vecs[0] = '{3, 0, 0, 17, 15, 11, 18};
    vecs[1] = '{0, 0, 0,  0,  2, -1,  3};
    vecs[2] = '{1, 0, 0,  0, 13,  9, 14};
    vecs[3] = '{2, 3, 5,  0, 19, 15, 20};
    vecs[4] = '{4, 0, 0, 20, 16, 12, 21};
    gv[0] = '{1'b0, 0, 1'b0}; gv[1] = '{1'b0, 0, 1'b0};
    gv[2] = '{1'b1, 0, 1'b0}; gv[3] = '{1'b0, 1, 1'b1};
    gv[4] = '{1'b0, 1, 1'b0}; gv[5] = '{1'b1, 1, 1'b0};
    gv[6] = '{1'b0, 2, 1'b1}; gv[7] = '{1'b0, 2, 1'b0};

    reset = 1'b1; cmd_valid = 1'b0; cmd_k = '0; abort = 1'b0; op_valid = 1'b0; done_ready = 1'b0;
    g_cmd_valid = 1'b0; g_cmd_k = KW'(2); g_abort = 1'b0; g_op_valid = 1'b0; g_done_ready = 1'b0;
    #1;
    check("reset_state", dut_vec(), pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0));
    check("reset_state_gap", 32'({g_cmd_ready, g_busy, g_pe_clear, g_done_valid, g_op_req,
                                  g_beat_idx, g_pe_start}), 32'({5'b10000, 24'h0}));
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    // Directed jobs
    for (int v = 0; v < 5; v++) begin
      for (int t = 0; t < MAXT; t++) begin
        ov_a[t] = !(t >= vecs[v].stall_s && t < vecs[v].stall_s + vecs[v].stall_len);
        dr_a[t] = (t >= vecs[v].dr_at);
      end
      run_job(vecs[v].k, df, pl, ia);
      check($sformatf("vec%0d done_first", v), 32'(df), 32'(vecs[v].exp_done));
      check($sformatf("vec%0d pe15_last", v), 32'(pl), 32'(vecs[v].exp_pe15));
      check($sformatf("vec%0d idle_at", v), 32'(ia), 32'(vecs[v].exp_idle));
    end

    // Randomized jobs with feeder stalls and consumer back-pressure
    for (int n = 0; n < 20; n++) begin
      k  = int'($urandom_range(0, 8));
      p  = int'($urandom_range(30, 100));
      pd = int'($urandom_range(20, 100));
      for (int t = 0; t < MAXT; t++) begin
        ov_a[t] = (t > 60) || (int'($urandom_range(1, 100)) <= p);
        dr_a[t] = (t > 100) || (int'($urandom_range(1, 100)) <= pd);
      end
      run_job(k, df, pl, ia);
    end

    // BEAT_GAP=3 instance, k=2
    for (int t = 0; t < 18; t++) begin
      g_cmd_valid = (t == 0); g_op_valid = 1'b1; g_done_ready = 1'b1;
      @(negedge clk);
      if (t < 8)
        check($sformatf("gap t=%0d", t), 32'({g_op_req, g_beat_idx, g_pe_start[0]}),
              32'({gv[t].oq, KW'(gv[t].bi), gv[t].pe0}));
      if (t == 15) check("gap done_early", 32'(g_done_valid), 32'(0));
      if (t == 16) check("gap done", 32'(g_done_valid), 32'(1));
      if (t == 17) check("gap idle", 32'({g_busy, g_cmd_ready}), 32'(1));
      @(posedge clk); #1;
    end
    g_cmd_valid = 1'b0;

    // Abort two cycles after the first fire
    cmd_valid = 1'b1; cmd_k = KW'(5); op_valid = 1'b1; done_ready = 1'b0; abort = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'(1));
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort_after", dut_vec(), pack(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0));
    acc_pe = 1'b0; acc_dv = 1'b0; acc_pc = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      acc_pe |= (pe_start != '0); acc_dv |= done_valid; acc_pc |= pe_clear;
    end
    check("abort_quiet", 32'({acc_pe, acc_dv, acc_pc, busy, cmd_ready}), 32'(1));
    prev_bi = 0;
    @(posedge clk); #1;

    // Abort while idle blocks a command
    cmd_valid = 1'b1; abort = 1'b1;
    @(negedge clk);
    check("idle_abort_ready", 32'(cmd_ready), 32'(0));
    @(posedge clk); #1;
    cmd_valid = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("idle_abort_after", 32'({busy, pe_clear, cmd_ready}), 32'(3'b011));
    @(posedge clk); #1;

    // Asynchronous reset in DRAIN
    cmd_valid = 1'b1; cmd_k = KW'(2); op_valid = 1'b1; done_ready = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin @(posedge clk); #1; end
    check("pre_reset_pe", 32'(pe_start != '0), 32'(1));
    #1; reset = 1'b1; #1;
    check("async_reset", dut_vec(), pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0));
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0; prev_bi = 0;
    for (int t = 0; t < MAXT; t++) begin ov_a[t] = 1'b1; dr_a[t] = 1'b1; end
    run_job(1, df, pl, ia);
    check("post_reset done_first", 32'(df), 32'(13));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
